// File: rtl/mem_io_bridge.sv
// mem_io_bridge: cpu bus to 128KB RAM plus I/O page 0x3xxxx (UART TX FIFO, RX pop, cycle counter, stop flag).
// Reads return on cpu_din one cycle after the address; cpu_rdy drops while the TX FIFO is full.

module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          wr_ok;
    logic          rd_ok;

    assign empty    = (cnt == '0);
    assign full     = cnt[AW];
    assign wr_ok    = push & ~full;
    assign rd_ok    = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            if (wr_ok && !rd_ok) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (rd_ok && !wr_ok) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

module mem_io_bridge #(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RAM_AW        = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       cpu_a,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_rdy,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_pop,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              prog_stop
);
    typedef enum logic [2:0] {
        SEL_RAM, SEL_RX, SEL_CLK0, SEL_CLK1, SEL_CLK2, SEL_CLK3, SEL_ZERO
    } sel_t;

    sel_t        sel_q;
    sel_t        sel_d;
    logic [7:0]  rx_q;
    logic [31:0] counter;
    logic [31:0] snap;
    logic        io;
    logic        is_rx;
    logic        is_stop;
    logic        is_clk;
    logic        rd_en;
    logic        wr_en;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  tx_push_dat;
    logic [7:0]  tx_head;
    logic        unused_hi;

    assign unused_hi = ^cpu_a[31:18];

    // Every presented address is an access whenever the bridge is ready.
    assign cpu_rdy = rdy_in & ~tx_full;
    assign rd_en   = cpu_rdy & ~cpu_wr;
    assign wr_en   = cpu_rdy & cpu_wr;

    assign io      = (cpu_a[17:16] == 2'b11);
    assign is_rx   = (cpu_a[17:0] == 18'h30000);
    assign is_stop = (cpu_a[17:0] == 18'h30004);
    assign is_clk  = (cpu_a[17:2] == 16'hC001);

    assign ram_a     = cpu_a[RAM_AW-1:0];
    assign ram_we    = wr_en & ~io;
    assign ram_wdata = ram_we ? cpu_dout : 8'h00;
    assign rx_pop    = rd_en & is_rx & rx_valid;

    // A stop write queues a NUL so the host sees the program end in the byte stream.
    assign tx_push     = wr_en & (is_stop | (is_rx & (cpu_dout != 8'h00)));
    assign tx_push_dat = is_stop ? 8'h00 : cpu_dout;
    assign tx_pop      = ~tx_empty & tx_ready;
    assign tx_valid    = ~tx_empty;
    assign tx_data     = tx_empty ? 8'h00 : tx_head;

    sync_fifo #(
        .W  (8),
        .AW (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .push     (tx_push),
        .push_dat (tx_push_dat),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .empty    (tx_empty),
        .full     (tx_full)
    );

    always_comb begin
        sel_d = SEL_RAM;
        if (io) begin
            sel_d = SEL_ZERO;
            if (is_rx) begin
                sel_d = SEL_RX;
            end else if (is_clk) begin
                case (cpu_a[1:0])
                    2'd0:    sel_d = SEL_CLK0;
                    2'd1:    sel_d = SEL_CLK1;
                    2'd2:    sel_d = SEL_CLK2;
                    default: sel_d = SEL_CLK3;
                endcase
            end
        end
    end

    always_comb begin
        cpu_din = 8'h00;
        case (sel_q)
            SEL_RAM:  cpu_din = ram_rdata;
            SEL_RX:   cpu_din = rx_q;
            SEL_CLK0: cpu_din = snap[7:0];
            SEL_CLK1: cpu_din = snap[15:8];
            SEL_CLK2: cpu_din = snap[23:16];
            SEL_CLK3: cpu_din = snap[31:24];
            default:  cpu_din = 8'h00;
        endcase
    end

    // Free-running: counts even while the board holds rdy_in low.
    always_ff @(posedge clk_in) begin
        if (!rst_in) counter <= '0;
        else         counter <= counter + 32'd1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sel_q     <= SEL_RAM;
            rx_q      <= 8'h00;
            snap      <= '0;
            prog_stop <= 1'b0;
        end else begin
            if (rd_en) begin
                sel_q <= sel_d;
                if (is_rx)   rx_q <= rx_valid ? rx_data : 8'h00;
                if (is_stop) snap <= counter;
            end
            if (wr_en && is_stop) prog_stop <= 1'b1;
        end
    end
endmodule
